// File: rtl/instr_loader.sv
// ---------------------------------------------------------------------------
// instr_loader
//   Boot-time program loader. Receives a length-prefixed, checksummed byte
//   stream (LEN lo, LEN hi, LEN payload bytes, CHK) and writes each payload
//   byte to instruction memory at BASE_ADDR + offset. The CPU is held in
//   reset until an image has loaded with a good checksum.
//
// Ports
//   clk_i, rst_n_i      clock, synchronous active-low reset
//   start_i             begin a load (honoured in IDLE/DONE/ERR only)
//   in_valid_i/in_data_i/in_ready_o   byte stream, valid/ready handshake
//   we_o/waddr_o/wdata_o              instruction memory byte write port
//   cpu_rst_n_o         CPU reset, released only in DONE
//   busy_o/done_o/error_o              load status
//   byte_count_o        payload bytes written in the current load
// ---------------------------------------------------------------------------
module instr_loader #(
    parameter int          ADDR_WIDTH = 12,
    parameter logic [31:0] BASE_ADDR  = 32'hBFC00000
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  start_i,
    input  logic                  in_valid_i,
    input  logic [7:0]            in_data_i,
    output logic                  in_ready_o,
    output logic                  we_o,
    output logic [31:0]           waddr_o,
    output logic [7:0]            wdata_o,
    output logic                  cpu_rst_n_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  error_o,
    output logic [ADDR_WIDTH:0]   byte_count_o
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_LEN_LO = 3'd1;
    localparam logic [2:0] S_LEN_HI = 3'd2;
    localparam logic [2:0] S_DATA   = 3'd3;
    localparam logic [2:0] S_CHECK  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;
    localparam logic [2:0] S_ERR    = 3'd6;

    // Largest legal image length, in 17 bits so a 16-bit LEN compares cleanly.
    localparam logic [16:0] CAP = 17'd1 << ADDR_WIDTH;

    logic [2:0]            state_q, state_d;
    logic [15:0]           len_q, len_d;
    logic [7:0]            sum_q, sum_d;
    logic [ADDR_WIDTH:0]   off_q, off_d;
    logic                  we_q, we_d;
    logic [31:0]           waddr_q, waddr_d;
    logic [7:0]            wdata_q, wdata_d;

    logic                  accept;
    logic [15:0]           len_full;
    logic [ADDR_WIDTH:0]   off_inc;
    logic [7:0]            sum_chk;

    // Status is a pure decode of the registered state: no path from in_valid.
    assign in_ready_o  = (state_q == S_LEN_LO) || (state_q == S_LEN_HI) ||
                         (state_q == S_DATA)   || (state_q == S_CHECK);
    assign busy_o      = in_ready_o;
    assign done_o      = (state_q == S_DONE);
    assign error_o     = (state_q == S_ERR);
    assign cpu_rst_n_o = (state_q == S_DONE);

    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    // The write offset doubles as the payload byte counter: both are cleared
    // at LEN_HI and advance together on each payload accept.
    assign byte_count_o = off_q;

    assign accept   = in_valid_i && in_ready_o;
    assign len_full = {in_data_i, len_q[7:0]};
    assign off_inc  = off_q + 1'b1;
    assign sum_chk  = sum_q + in_data_i;

    always_comb begin
        state_d = state_q;
        len_d   = len_q;
        sum_d   = sum_q;
        off_d   = off_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_DONE, S_ERR: begin
                if (start_i) state_d = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (accept) begin
                    len_d[7:0] = in_data_i;
                    state_d    = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (accept) begin
                    len_d = len_full;
                    sum_d = 8'h00;
                    off_d = '0;
                    if ({1'b0, len_full} > CAP) state_d = S_ERR;
                    else if (len_full == 16'h0000) state_d = S_CHECK;
                    else state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (accept) begin
                    we_d    = 1'b1;
                    waddr_d = BASE_ADDR + 32'(off_q);
                    wdata_d = in_data_i;
                    sum_d   = sum_chk;
                    off_d   = off_inc;
                    if (17'(off_inc) == {1'b0, len_q}) state_d = S_CHECK;
                end
            end
            S_CHECK: begin
                if (accept) state_d = (sum_chk == 8'h00) ? S_DONE : S_ERR;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            len_q   <= '0;
            sum_q   <= '0;
            off_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= BASE_ADDR;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            off_q   <= off_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

endmodule
